baccarat_fsm: RTL and testbench
===============================

Name: baccarat_fsm

Overview:
Controller for the baccarat datapath. It sequences the card deal by pulsing exactly one datapath load strobe per slow_clock cycle. It consumes the datapath's pscore, dscore and pcard3 outputs to apply the player and banker third-card rules. It then drives the player and dealer win lights and holds the result until reset.

Parameters:
none (state encoding and rule constants live in the shared package)

Ports:
slow_clock  in  1  system clock; all state updates on rising edge
resetb  in  1  synchronous reset, active-high; sampled on slow_clock rising edge
pscore  in  4  player hand score 0-9 from datapath
dscore  in  4  dealer hand score 0-9 from datapath
pcard3  in  4  player third card rank 0-13 from datapath (0 = no card; 10-13 = face cards)
load_pcard1  out  1  datapath load strobe, player card 1
load_pcard2  out  1  datapath load strobe, player card 2
load_pcard3  out  1  datapath load strobe, player card 3
load_dcard1  out  1  datapath load strobe, dealer card 1
load_dcard2  out  1  datapath load strobe, dealer card 2
load_dcard3  out  1  datapath load strobe, dealer card 3
player_win_light  out  1  player wins (also set on a tie)
dealer_win_light  out  1  dealer wins (also set on a tie)
state_out  out  4  current state encoding, for debug and bench

Behaviour:
- Clock and reset: one clock, slow_clock. Reset is synchronous and active-high on resetb.
- Reset values:
  - state = IDLE.
  - All six load strobes = 0.
  - Both win lights = 0.
  - state_out = IDLE encoding.
- Output decoding:
  - Load strobes are Moore outputs decoded from state; at most one strobe is high in any cycle.
  - The datapath captures a card on the slow_clock edge that ends a load state.
  - The updated scores and pcard3 are valid in the following cycle.
- States and transitions:
  - IDLE: no load. Goes to P1.
  - P1: load_pcard1. Goes to D1.
  - D1: load_dcard1. Goes to P2.
  - P2: load_pcard2. Goes to D2.
  - D2: load_dcard2. Goes to EVAL.
  - EVAL: no load; the four-card scores are valid here.
    - If pscore >= 8 or dscore >= 8 (natural), go to RESULT.
    - Else if pscore <= 5, go to P3.
    - Else (player stands on 6 or 7): if dscore <= 5 go to D3, otherwise go to RESULT.
  - P3: load_pcard3. Goes to EVAL3.
  - EVAL3: no load; pcard3 is valid here.
    - Compute v = card value of pcard3: v = 0 if rank >= 10, otherwise v = rank.
    - Banker draws, going to D3, when any of these holds:
      - dscore <= 2
      - dscore = 3 and v != 8
      - dscore = 4 and v in 2..7
      - dscore = 5 and v in 4..7
      - dscore = 6 and v in 6..7
    - Otherwise (including dscore = 7) go to RESULT.
  - D3: load_dcard3. Goes to RESULT.
  - RESULT: no load; the final scores are valid here.
    - On the edge leaving RESULT, register player_win_light = (pscore >= dscore).
    - On the same edge, register dealer_win_light = (dscore >= pscore).
    - Goes to DONE.
  - DONE: no load. Lights hold. State holds until reset.
- Timing from the first edge with resetb = 0 (cycle 0 = IDLE):
  - load_pcard1 is high in cycle 1; D2 is cycle 4; EVAL is cycle 5.
  - Natural: lights are valid in cycle 7.
  - Both players draw: lights are valid in cycle 10.
- Comparisons are unsigned 4-bit. Score inputs above 9 are not legal and produce don't-care behaviour.
- Reset mid-operation: asserting resetb in any state forces IDLE, clears the lights and clears all strobes on the next edge. Reset has priority over every transition.
- Lights are driven only from a register and are 0 in every state other than DONE.

Decomposition:
- Package baccarat_pkg contains:
  - state enum: IDLE, P1, D1, P2, D2, EVAL, P3, EVAL3, D3, RESULT, DONE, with 4-bit encoding.
  - constants NATURAL_MIN = 8, PLAYER_DRAW_MAX = 5, FACE_RANK_MIN = 10.
  - function card_value(rank) returning 0..9.
- Sub-module banker_draw_rule: combinational; inputs dscore and pcard3 value; output draw. It implements the EVAL3 table and is reused by the bench as the reference model.

Test Plan:
- Natural: bench sets pscore = 8, dscore = 3 in EVAL -> no load_pcard3 or load_dcard3 ever; cycle 7 player_win_light = 1, dealer_win_light = 0.
- Player stands, banker draws: pscore = 6, dscore = 4 in EVAL -> load_dcard3 high exactly in cycle 6, load_pcard3 never; final pscore = 6, dscore = 7 -> dealer_win_light = 1 only.
- Face-card third card: pscore = 3, dscore = 5, pcard3 = 12 (v = 0) -> EVAL3 goes to RESULT with no load_dcard3. Repeat with pcard3 = 4 -> load_dcard3 high in cycle 8.
- Banker on 3 versus an 8: dscore = 3, pcard3 = 8 -> stand. Final pscore = 7, dscore = 7 -> both lights = 1 (tie).
- Both stand: pscore = 7, dscore = 6 in EVAL -> no third-card loads; player_win_light = 1 in cycle 7.
- Reset mid-hand: assert resetb during P3 -> next cycle state_out = IDLE, all strobes 0, lights 0. On deassert, load_pcard1 is high one cycle later.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat controller: state encoding, rule
// thresholds and the card-rank-to-value helper.
package baccarat_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    P1     = 4'd1,
    D1     = 4'd2,
    P2     = 4'd3,
    D2     = 4'd4,
    EVAL   = 4'd5,
    P3     = 4'd6,
    EVAL3  = 4'd7,
    D3     = 4'd8,
    RESULT = 4'd9,
    DONE   = 4'd10
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] BANKER_DRAW_MAX = 4'd5;
  localparam logic [3:0] FACE_RANK_MIN   = 4'd10;

  // Tens and face cards count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= FACE_RANK_MIN) ? 4'd0 : rank;
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card decision once the player has drawn a third card,
// indexed by the banker score and the value of the player's third card.
module banker_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] pvalue,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pvalue != 4'd8);
      4'd4:             draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
      4'd5:             draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
      4'd6:             draw = (pvalue >= 4'd6) && (pvalue <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat deal controller: one datapath load strobe per state, third-card
// rules, and registered win lights that hold until reset.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic [3:0] state_out
);

  state_t     state_q, state_d;
  logic       player_win_q, player_win_d;
  logic       dealer_win_q, dealer_win_d;
  logic [3:0] pcard3_value;
  logic       banker_draw;

  assign pcard3_value = card_value(pcard3);

  banker_draw_rule u_banker_draw_rule (
    .dscore (dscore),
    .pvalue (pcard3_value),
    .draw   (banker_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_q      <= IDLE;
      player_win_q <= 1'b0;
      dealer_win_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_win_q <= player_win_d;
      dealer_win_q <= dealer_win_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    player_win_d = 1'b0;
    dealer_win_d = 1'b0;
    load_pcard1  = 1'b0;
    load_pcard2  = 1'b0;
    load_pcard3  = 1'b0;
    load_dcard1  = 1'b0;
    load_dcard2  = 1'b0;
    load_dcard3  = 1'b0;
    case (state_q)
      IDLE: state_d = P1;
      P1: begin
        load_pcard1 = 1'b1;
        state_d     = D1;
      end
      D1: begin
        load_dcard1 = 1'b1;
        state_d     = P2;
      end
      P2: begin
        load_pcard2 = 1'b1;
        state_d     = D2;
      end
      D2: begin
        load_dcard2 = 1'b1;
        state_d     = EVAL;
      end
      // Four-card scores are valid here; naturals end the hand immediately.
      EVAL: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          state_d = RESULT;
        end else if (pscore <= PLAYER_DRAW_MAX) begin
          state_d = P3;
        end else if (dscore <= BANKER_DRAW_MAX) begin
          state_d = D3;
        end else begin
          state_d = RESULT;
        end
      end
      P3: begin
        load_pcard3 = 1'b1;
        state_d     = EVAL3;
      end
      EVAL3: state_d = banker_draw ? D3 : RESULT;
      D3: begin
        load_dcard3 = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        player_win_d = (pscore >= dscore);
        dealer_win_d = (dscore >= pscore);
        state_d      = DONE;
      end
      DONE: begin
        player_win_d = player_win_q;
        dealer_win_d = dealer_win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign player_win_light = player_win_q;
  assign dealer_win_light = dealer_win_q;
  assign state_out        = state_q;

endmodule

// File: tb/tb_baccarat_fsm.sv
// Bench for baccarat_fsm: acts as the datapath, checks every cycle of each hand
// against a queued expected trace, and checks the banker rule table exhaustively.
module tb_baccarat_fsm;
  import baccarat_pkg::*;

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
  logic [3:0] state_out;
  logic [5:0] ld_obs;

  logic [3:0] bd_dscore = 4'd0;
  logic [3:0] bd_val = 4'd0;
  logic       bd_draw;

  always #5 clk = ~clk;

  baccarat_fsm dut (
    .slow_clock       (clk),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .state_out        (state_out)
  );

  banker_draw_rule u_rule (
    .dscore (bd_dscore),
    .pvalue (bd_val),
    .draw   (bd_draw)
  );

  assign ld_obs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};

  typedef struct packed {
    state_t     st;
    logic [5:0] ld;
    logic       pw;
    logic       dw;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Strobe order: {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
  function automatic logic [5:0] ld_of(input state_t s);
    case (s)
      P1:      return 6'b100000;
      D1:      return 6'b010000;
      P2:      return 6'b001000;
      D2:      return 6'b000100;
      P3:      return 6'b000010;
      D3:      return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic push(input state_t s, input logic pw, input logic dw);
    exp_t e;
    e.st = s;
    e.ld = ld_of(s);
    e.pw = (s == DONE) ? pw : 1'b0;
    e.dw = (s == DONE) ? dw : 1'b0;
    sb.push_back(e);
  endtask

  // path: 0 = EVAL->RESULT, 1 = EVAL->D3, 2 = P3 then banker stands, 3 = P3 then banker draws
  task automatic push_hand(input int path, input logic pw, input logic dw);
    push(IDLE, pw, dw); push(P1, pw, dw); push(D1, pw, dw);
    push(P2, pw, dw);   push(D2, pw, dw); push(EVAL, pw, dw);
    case (path)
      1: push(D3, pw, dw);
      2: begin push(P3, pw, dw); push(EVAL3, pw, dw); end
      3: begin push(P3, pw, dw); push(EVAL3, pw, dw); push(D3, pw, dw); end
      default: ;
    endcase
    push(RESULT, pw, dw);
    push(DONE, pw, dw); push(DONE, pw, dw); push(DONE, pw, dw);
  endtask

  // Resets the DUT, then plays the datapath role while draining the queue.
  task automatic run_hand(input string name, input logic [3:0] p4, input logic [3:0] d4,
                          input logic [3:0] pc3, input logic [3:0] pf, input logic [3:0] df);
    exp_t e;
    bit   first;
    first  = 1'b1;
    pscore = p4;
    dscore = d4;
    pcard3 = 4'd0;
    resetb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resetb = 1'b0;
    while (sb.size() > 0) begin
      if (!first) @(negedge clk);
      first = 1'b0;
      e = sb.pop_front();
      chk($sformatf("%s.state", name), {4'h0, state_out}, {4'h0, e.st});
      chk($sformatf("%s.load", name), {2'b00, ld_obs}, {2'b00, e.ld});
      chk($sformatf("%s.lights", name), {6'b0, player_win_light, dealer_win_light},
          {6'b0, e.pw, e.dw});
      if (load_pcard3) begin
        pscore = pf;
        pcard3 = pc3;
      end
      if (load_dcard3) dscore = df;
    end
  endtask

  logic [9:0] rule_mask [10];

  initial begin
    push_hand(0, 1'b1, 1'b0); run_hand("natural", 4'd8, 4'd3, 4'd0, 4'd8, 4'd3);
    push_hand(0, 1'b0, 1'b1); run_hand("dealer_natural", 4'd2, 4'd9, 4'd0, 4'd2, 4'd9);
    push_hand(1, 1'b0, 1'b1); run_hand("bank_draw", 4'd6, 4'd4, 4'd0, 4'd6, 4'd7);
    push_hand(2, 1'b0, 1'b1); run_hand("face_third", 4'd3, 4'd5, 4'd12, 4'd3, 4'd5);
    push_hand(3, 1'b1, 1'b0); run_hand("four_third", 4'd3, 4'd5, 4'd4, 4'd7, 4'd2);
    push_hand(2, 1'b1, 1'b1); run_hand("b3_vs_8", 4'd5, 4'd3, 4'd8, 4'd3, 4'd3);
    push_hand(2, 1'b1, 1'b1); run_hand("b7_stands", 4'd1, 4'd7, 4'd6, 4'd7, 4'd7);
    push_hand(0, 1'b1, 1'b0); run_hand("both_stand", 4'd7, 4'd6, 4'd0, 4'd7, 4'd6);

    // Reset asserted while in P3.
    push(IDLE, 1'b0, 1'b0); push(P1, 1'b0, 1'b0); push(D1, 1'b0, 1'b0);
    push(P2, 1'b0, 1'b0);   push(D2, 1'b0, 1'b0); push(EVAL, 1'b0, 1'b0);
    push(P3, 1'b0, 1'b0);
    run_hand("mid_pre", 4'd4, 4'd4, 4'd2, 4'd6, 4'd4);
    resetb = 1'b1;
    @(negedge clk);
    chk("mid_reset.state", {4'h0, state_out}, {4'h0, IDLE});
    chk("mid_reset.load", {2'b00, ld_obs}, 8'h00);
    chk("mid_reset.lights", {6'b0, player_win_light, dealer_win_light}, 8'h00);
    resetb = 1'b0;
    @(negedge clk);
    chk("mid_restart.state", {4'h0, state_out}, {4'h0, P1});
    chk("mid_restart.load", {2'b00, ld_obs}, 8'h20);

    // Banker table, bit v set where the banker draws.
    rule_mask[0] = 10'b1111111111;
    rule_mask[1] = 10'b1111111111;
    rule_mask[2] = 10'b1111111111;
    rule_mask[3] = 10'b1011111111;
    rule_mask[4] = 10'b0011111100;
    rule_mask[5] = 10'b0011110000;
    rule_mask[6] = 10'b0011000000;
    rule_mask[7] = 10'b0000000000;
    rule_mask[8] = 10'b0000000000;
    rule_mask[9] = 10'b0000000000;
    for (int d = 0; d < 10; d++) begin
      for (int v = 0; v < 10; v++) begin
        bd_dscore = d[3:0];
        bd_val    = v[3:0];
        #1;
        chk($sformatf("rule.d%0d.v%0d", d, v), {7'b0, bd_draw}, {7'b0, rule_mask[d][v]});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
